ebus_xfer: RTL and testbench
============================

# ebus_xfer

EBUS transfer sequencer between the KL10 EDP data path and the EBUS. For output transfers it gates EDP AD onto the bus via `adToEBUS_L`/`adToEBUS_R` and runs the demand/transfer handshake. For input transfers it captures device data into a holding register, which drives EDP's `ebusD` input. A cycle counter aborts transfers that devices never acknowledge.

## Interface
Parameters:
- `TIMEOUT`, 63: cycles in DEMAND without `ebusXfer` before abort; legal range 1..255.
- `SETUP`, 2: cycles controller select and function are driven before demand; legal range 1..7.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request from CLK control; honoured only in IDLE.
- `dirOut`  in  1  1 = CPU→device (AD to bus), 0 = device→CPU.
- `func`  in  [0:2]  EBUS function code, sampled on accepted `start`.
- `cs`  in  [0:6]  controller select, sampled on accepted `start`.
- `AD`  in  [0:35]  EDP adder output.
- `ebusDataIn`  in  [0:35]  EBUS data lines, as received.
- `ebusXfer`  in  1  device transfer acknowledge.
- `ebusD`  out  [0:35]  holding register to EDP.
- `ebusDataOut`  out  [0:35]  data driven to bus; valid only while `ebusDrive` is high.
- `ebusDrive`  out  1  bus driver enable.
- `adToEBUS_L`, `adToEBUS_R`  out  1 each  EDP gating of AD halves.
- `ebusCS`  out  [0:6]  latched controller select.
- `ebusFunc`  out  [0:2]  latched function code.
- `ebusDemand`  out  1  demand to device.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a transfer completes normally.
- `timeout`  out  1  one-cycle pulse when a transfer aborts.

## Operation
- States and transitions:
  - IDLE: `start` → SETUP.
  - SETUP: after `SETUP` cycles → DEMAND.
  - DEMAND: `ebusXfer` → HOLD; timer reaching `TIMEOUT` → ABORT.
  - HOLD: `ebusXfer` low → DONE.
  - DONE → IDLE.
  - ABORT → IDLE.
- On accepted `start`: latch `dirOut`, `func` and `cs`. Later changes to these inputs are ignored until IDLE.
- Output direction: `adToEBUS_L`, `adToEBUS_R` and `ebusDrive` are high from SETUP through HOLD. `ebusDataOut` = AD registered each cycle while driving, so EDP may settle AD during SETUP.
- Input direction: `ebusD` loads `ebusDataIn` on the DEMAND cycle that sees `ebusXfer`. `ebusD` holds that value until the next input load or reset. Output transfers and aborts never modify `ebusD`.
- `ebusDemand`: high in DEMAND and HOLD.
- `ebusCS`/`ebusFunc`: hold their latched values from SETUP through HOLD; zero otherwise.
- Timer: 8 bits, cleared on entering DEMAND, incremented each DEMAND cycle; it never wraps.
- `ebusXfer` and timeout in the same cycle: `ebusXfer` wins.
- `start` outside IDLE: ignored, with no queueing.

## Timing
- Reset: all outputs 0, state IDLE, `ebusD` = 0. Reset mid-transfer drops demand and drive on the next edge, with no `done` or `timeout` pulse.
- Latency, `start` to `ebusDemand`: `SETUP`+1 edges.
- Latency, `ebusXfer` rise to `ebusD` valid: 1 edge.
- `done` fires 1 edge after `ebusXfer` falls.
- Minimum transfer with immediate acknowledge and `SETUP`=2: 6 cycles from `start` to back in IDLE.
- `ebusXfer` already high on DEMAND entry is accepted immediately.
- `ebusXfer` stuck high in HOLD: remains in HOLD indefinitely, with no timeout there.

## Configuration
- `EBUS_PARITY_EN` defined:
  - Adds port `ebusParOut` (out, 1), odd parity of `ebusDataOut`.
  - Adds port `ebusParIn` (in, 1).
  - Adds port `parErr` (out, 1), a one-cycle pulse in DONE for an input transfer whose captured data plus `ebusParIn` has even parity. `ebusD` still loads.
- `EBUS_PARITY_EN` undefined: no parity ports or logic.

## Structure
- Shared package `ebus_pkg` holds:
  - state enum;
  - function-code constants: `EBUS_FUNC_READ`=0, `EBUS_FUNC_WRITE`=1, `EBUS_FUNC_CONO`=2, `EBUS_FUNC_CONI`=3, `EBUS_FUNC_DATAO`=4, `EBUS_FUNC_DATAI`=5;
  - default `TIMEOUT`/`SETUP`.
- Single flat module; no sub-modules. Parity uses reduction XOR inline.

## Test plan
- Output transfer: reset; `start`, `dirOut`=1, `cs`=7'o40, `AD`=36'o123456765432; `ebusXfer` high 3 cycles after demand → `ebusDataOut`=36'o123456765432 and `ebusCS`=7'o40 during demand; `done` pulses once; `ebusD` stays 0.
- Input transfer: `dirOut`=0, `ebusDataIn`=36'o777000000777, acknowledge after 1 cycle → `ebusD`=36'o777000000777 after release; `adToEBUS_L`/`adToEBUS_R` never high.
- Timeout: `TIMEOUT`=5, no `ebusXfer` → `timeout` pulses exactly 6 cycles after demand rises; `ebusDemand` low the next cycle; `busy` drops.
- `start` pulsed during DEMAND → ignored; exactly one `done`; latched `cs` unchanged.
- Reset asserted in HOLD → next cycle all outputs 0, no `done`; a new `start` works normally.
- With `EBUS_PARITY_EN` defined: input 36'o1 with `ebusParIn`=1 → `parErr` pulses; with `ebusParIn`=0 → no `parErr`.

Source files
------------

// File: rtl/ebus_pkg.sv
// Shared types and constants for the EBUS transfer sequencer.
package ebus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DEMAND,
        ST_HOLD,
        ST_DONE,
        ST_ABORT
    } ebusState_e;

    localparam logic [0:2] EBUS_FUNC_READ  = 3'd0;
    localparam logic [0:2] EBUS_FUNC_WRITE = 3'd1;
    localparam logic [0:2] EBUS_FUNC_CONO  = 3'd2;
    localparam logic [0:2] EBUS_FUNC_CONI  = 3'd3;
    localparam logic [0:2] EBUS_FUNC_DATAO = 3'd4;
    localparam logic [0:2] EBUS_FUNC_DATAI = 3'd5;

    localparam int EBUS_TIMEOUT_DEFAULT = 63;
    localparam int EBUS_SETUP_DEFAULT   = 2;

endpackage

// File: rtl/ebus_xfer.sv
// EBUS transfer sequencer between the EDP data path and the EBUS.
// Optional odd-parity generation/checking is enabled by defining EBUS_PARITY_EN.
module ebus_xfer
    import ebus_pkg::*;
#(
    parameter int TIMEOUT = EBUS_TIMEOUT_DEFAULT,
    parameter int SETUP   = EBUS_SETUP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dirOut,
    input  logic [0:2]  func,
    input  logic [0:6]  cs,
    input  logic [0:35] AD,
    input  logic [0:35] ebusDataIn,
    input  logic        ebusXfer,
    output logic [0:35] ebusD,
    output logic [0:35] ebusDataOut,
    output logic        ebusDrive,
    output logic        adToEBUS_L,
    output logic        adToEBUS_R,
    output logic [0:6]  ebusCS,
    output logic [0:2]  ebusFunc,
    output logic        ebusDemand,
    output logic        busy,
    output logic        done,
`ifdef EBUS_PARITY_EN
    input  logic        ebusParIn,
    output logic        ebusParOut,
    output logic        parErr,
`endif
    output logic        timeout
);

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);

    ebusState_e  state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        dir_q;
    logic [0:2]  func_q;
    logic [0:6]  cs_q;
    logic [0:35] dataOut_q, dataOut_d;
    logic [0:35] ebusD_q;
    logic        accept;
    logic        dirNext;
    logic        driveNext;
    logic        inputLoad;
    logic        active;
    logic        drive;

    assign accept    = (state_q == ST_IDLE) && start;
    assign dirNext   = accept ? dirOut : dir_q;
    assign inputLoad = (state_q == ST_DEMAND) && ebusXfer && !dir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETUP;
            ST_SETUP:  if (timer_q == SETUP_LAST) state_d = ST_DEMAND;
            ST_DEMAND: begin
                // An acknowledge arriving on the last allowed cycle still wins over the abort.
                if (ebusXfer) begin
                    state_d = ST_HOLD;
                end else if (timer_q == TIMEOUT_C) begin
                    state_d = ST_ABORT;
                end
            end
            ST_HOLD:   if (!ebusXfer) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // One counter paces SETUP and times DEMAND; it restarts on every state change.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (((state_q == ST_SETUP) || (state_q == ST_DEMAND)) && (timer_q != 8'hFF)) begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_comb begin
        driveNext = dirNext && ((state_d == ST_SETUP) || (state_d == ST_DEMAND) || (state_d == ST_HOLD));
        dataOut_d = driveNext ? AD : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            dir_q     <= 1'b0;
            func_q    <= '0;
            cs_q      <= '0;
            dataOut_q <= '0;
            ebusD_q   <= '0;
        end else begin
            timer_q   <= timer_d;
            dataOut_q <= dataOut_d;
            if (accept) begin
                dir_q  <= dirOut;
                func_q <= func;
                cs_q   <= cs;
            end
            if (inputLoad) begin
                ebusD_q <= ebusDataIn;
            end
        end
    end

    always_comb begin
        active     = (state_q == ST_SETUP) || (state_q == ST_DEMAND) || (state_q == ST_HOLD);
        drive      = active && dir_q;
        ebusDrive  = drive;
        adToEBUS_L = drive;
        adToEBUS_R = drive;
        ebusCS     = active ? cs_q : '0;
        ebusFunc   = active ? func_q : '0;
        ebusDemand = (state_q == ST_DEMAND) || (state_q == ST_HOLD);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        timeout    = (state_q == ST_ABORT);
    end

    assign ebusDataOut = dataOut_q;
    assign ebusD       = ebusD_q;

`ifdef EBUS_PARITY_EN
    logic parIn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parIn_q <= 1'b0;
        end else if (inputLoad) begin
            parIn_q <= ebusParIn;
        end
    end

    // Parity bit makes data plus parity odd; an even total on input is an error.
    assign ebusParOut = ebusDrive & ~(^dataOut_q);
    assign parErr     = (state_q == ST_DONE) && !dir_q && !(^{ebusD_q, parIn_q});
`endif

endmodule

// File: tb/tb_ebus_xfer.sv
// Scoreboard bench for ebus_xfer: random transfers against a cycle-count reference model.
// Define EBUS_PARITY_EN to also exercise the parity ports.
module tb_ebus_xfer;
    import ebus_pkg::*;

    localparam int TB_TIMEOUT = 5;
    localparam int TB_SETUP   = 2;
    localparam int NO_ACK     = 255;

    typedef struct {
        bit          isTimeout;
        bit          dir;
        logic [0:6]  cs;
        logic [0:2]  func;
        logic [0:35] dOut;
        logic [0:35] dExp;
        bit          parErr;
        bit          parOut;
        int          busyIdx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        dirOut;
    logic [0:2]  func;
    logic [0:6]  cs;
    logic [0:35] AD;
    logic [0:35] ebusDataIn;
    logic        ebusXfer;
    logic        ebusParIn;
    logic [0:35] ebusD;
    logic [0:35] ebusDataOut;
    logic        ebusDrive;
    logic        adToEBUS_L;
    logic        adToEBUS_R;
    logic [0:6]  ebusCS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand;
    logic        busy;
    logic        done;
    logic        timeout;
`ifdef EBUS_PARITY_EN
    logic        ebusParOut;
    logic        parErr;
`endif

    exp_t        sbQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [0:35] modelD = '0;

    ebus_xfer #(
        .TIMEOUT(TB_TIMEOUT),
        .SETUP  (TB_SETUP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dirOut     (dirOut),
        .func       (func),
        .cs         (cs),
        .AD         (AD),
        .ebusDataIn (ebusDataIn),
        .ebusXfer   (ebusXfer),
        .ebusD      (ebusD),
        .ebusDataOut(ebusDataOut),
        .ebusDrive  (ebusDrive),
        .adToEBUS_L (adToEBUS_L),
        .adToEBUS_R (adToEBUS_R),
        .ebusCS     (ebusCS),
        .ebusFunc   (ebusFunc),
        .ebusDemand (ebusDemand),
        .busy       (busy),
        .done       (done),
`ifdef EBUS_PARITY_EN
        .ebusParIn  (ebusParIn),
        .ebusParOut (ebusParOut),
        .parErr     (parErr),
`endif
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:35] rand36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    function automatic logic [127:0] allOut();
        logic [127:0] v;
        v = 128'({ebusD, ebusDataOut, ebusDrive, adToEBUS_L, adToEBUS_R, ebusCS, ebusFunc,
                  ebusDemand, busy, done, timeout});
`ifdef EBUS_PARITY_EN
        v = v | 128'({ebusParOut, parErr});
`endif
        return v;
    endfunction

    // One complete transfer: issue start, play the device side, wait for return to idle.
    task automatic applyStimulus(input bit dir, input logic [0:6] c, input logic [0:2] f,
                                 input logic [0:35] ad1, input logic [0:35] ad2,
                                 input logic [0:35] din, input int delay, input int hold,
                                 input bit parIn, input bit pokeStart);
        exp_t e;
        bit   toExp;
        toExp       = (delay > TB_TIMEOUT);
        e.isTimeout = toExp;
        e.dir       = dir;
        e.cs        = c;
        e.func      = f;
        e.dOut      = dir ? ad2 : '0;
        if (!toExp && !dir) modelD = din;
        e.dExp      = modelD;
        e.parErr    = !toExp && !dir && ((($countones(din) + int'(parIn)) % 2) == 0);
        e.parOut    = (($countones(ad2) % 2) == 0);
        e.busyIdx   = toExp ? (TB_SETUP + TB_TIMEOUT + 1) : (TB_SETUP + delay + 1 + hold);

        dirOut = dir;
        cs     = c;
        func   = f;
        AD     = ad1;
        start  = 1'b1;
        sbQ.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        dirOut     = ~dir;
        cs         = 7'($urandom());
        func       = 3'($urandom());
        AD         = ad2;
        ebusDataIn = rand36();

        for (int i = 0; i < 20 && !ebusDemand; i++) @(negedge clk);
        checkOutput("demand rise", 128'(ebusDemand), 128'(1));

        start = pokeStart;
        if (!toExp) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                start = 1'b0;
            end
            ebusXfer   = 1'b1;
            ebusDataIn = din;
            ebusParIn  = parIn;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                start      = 1'b0;
                ebusDataIn = rand36();
                ebusParIn  = ~parIn;
            end
            ebusXfer = 1'b0;
        end else begin
            @(negedge clk);
            start = 1'b0;
        end

        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        checkOutput("return to idle", 128'(busy), 128'(0));
    endtask

    // Monitor: checks bus presentation at demand rise and results at each done/timeout pulse.
    initial begin
        bit   prevBusy   = 1'b0;
        bit   prevDemand = 1'b0;
        bit   postPulse  = 1'b0;
        int   busyIdx    = 0;
        int   demCnt     = 0;
        int   adViol     = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (postPulse) begin
                checkOutput("busy after pulse", 128'(busy), 128'(0));
                checkOutput("demand after pulse", 128'(ebusDemand), 128'(0));
                postPulse = 1'b0;
            end
            if (busy && !prevBusy) busyIdx = 0;
            else if (busy) busyIdx++;
            if (ebusDemand && !prevDemand) begin
                demCnt = 1;
                if (sbQ.size() > 0) begin
                    e = sbQ[0];
                    checkOutput("start to demand", 128'(busyIdx), 128'(TB_SETUP));
                    checkOutput("ebusCS", 128'(ebusCS), 128'(e.cs));
                    checkOutput("ebusFunc", 128'(ebusFunc), 128'(e.func));
                    checkOutput("ebusDrive", 128'(ebusDrive), 128'(e.dir));
                    checkOutput("ebusDataOut", 128'(ebusDataOut), 128'(e.dOut));
`ifdef EBUS_PARITY_EN
                    checkOutput("ebusParOut", 128'(ebusParOut), 128'(e.dir ? e.parOut : 1'b0));
`endif
                end
            end else if (ebusDemand) begin
                demCnt++;
            end
            if (sbQ.size() > 0 && !sbQ[0].dir && (adToEBUS_L || adToEBUS_R)) adViol++;
            if (done || timeout) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected pulse", 128'({done, timeout}), 128'(0));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("done pulse", 128'(done), 128'(!e.isTimeout));
                    checkOutput("timeout pulse", 128'(timeout), 128'(e.isTimeout));
                    checkOutput("ebusD", 128'(ebusD), 128'(e.dExp));
                    checkOutput("busy length", 128'(busyIdx), 128'(e.busyIdx));
                    if (e.isTimeout)
                        checkOutput("demand cycles before abort", 128'(demCnt), 128'(TB_TIMEOUT + 1));
                    if (!e.dir)
                        checkOutput("AD gating on input", 128'(adViol), 128'(0));
`ifdef EBUS_PARITY_EN
                    checkOutput("parErr", 128'(parErr), 128'(e.parErr));
`endif
                    postPulse = 1'b1;
                end
                adViol = 0;
            end
            prevBusy   = busy;
            prevDemand = ebusDemand;
        end
    end

    initial begin
        bit   rDir;
        int   rDelay;
        int   rHold;
        reset      = 1'b1;
        start      = 1'b0;
        dirOut     = 1'b0;
        func       = '0;
        cs         = '0;
        AD         = '0;
        ebusDataIn = '0;
        ebusXfer   = 1'b0;
        ebusParIn  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", allOut(), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Output transfer, acknowledged three cycles into DEMAND.
        applyStimulus(1'b1, 7'o40, EBUS_FUNC_DATAO, 36'o123456765432, 36'o123456765432,
                      rand36(), 3, 2, 1'b0, 1'b0);
        // Input transfer, acknowledged after one cycle.
        applyStimulus(1'b0, 7'o12, EBUS_FUNC_DATAI, rand36(), rand36(), 36'o777000000777,
                      1, 1, 1'b0, 1'b0);
        // No acknowledge at all: abort.
        applyStimulus(1'b0, 7'o03, EBUS_FUNC_CONI, rand36(), rand36(), rand36(),
                      NO_ACK, 1, 1'b0, 1'b0);
        // Immediate acknowledge (minimum transfer) with a stray start during DEMAND.
        applyStimulus(1'b1, 7'o55, EBUS_FUNC_CONO, rand36(), rand36(), rand36(),
                      0, 1, 1'b0, 1'b1);
        // Acknowledge on the final allowed DEMAND cycle, then held high well past the timeout.
        applyStimulus(1'b0, 7'o77, EBUS_FUNC_READ, rand36(), rand36(), rand36(),
                      TB_TIMEOUT, 9, 1'b0, 1'b0);
`ifdef EBUS_PARITY_EN
        applyStimulus(1'b0, 7'o01, EBUS_FUNC_DATAI, rand36(), rand36(), 36'o1, 1, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 7'o01, EBUS_FUNC_DATAI, rand36(), rand36(), 36'o1, 1, 1, 1'b0, 1'b0);
`endif

        // Reset while in HOLD: everything clears, no pulse follows.
        dirOut = 1'b0;
        cs     = 7'o21;
        func   = EBUS_FUNC_WRITE;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !ebusDemand; i++) @(negedge clk);
        checkOutput("reset test demand", 128'(ebusDemand), 128'(1));
        ebusXfer   = 1'b1;
        ebusDataIn = rand36();
        @(negedge clk);
        checkOutput("reset test in hold", 128'(ebusDemand), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset mid-transfer outputs", allOut(), 128'(0));
        reset    = 1'b0;
        ebusXfer = 1'b0;
        modelD   = '0;
        repeat (3) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            rDir   = 1'($urandom());
            rDelay = $urandom_range(0, TB_TIMEOUT + 2);
            rHold  = $urandom_range(1, 8);
            applyStimulus(rDir, 7'($urandom()), 3'($urandom_range(0, 5)), rand36(), rand36(),
                          rand36(), rDelay, rHold, 1'($urandom()), 1'($urandom()));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 128'(sbQ.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
